// File: rtl/fir_pkg.sv
// Shared state type, width helpers and BRAM latency for the FIR scheduler.
package fir_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LOAD,
        S_CALC,
        S_DRAIN,
        S_OUT,
        S_DONE
    } fir_sched_state_e;

    localparam int BRAM_RD_LAT = 1;

    function automatic int tap_aw(input int max_tap_num);
        return $clog2(max_tap_num);
    endfunction

    function automatic int dat_cw(input int max_data_num);
        return $clog2(max_data_num) + 1;
    endfunction

endpackage

// File: rtl/fir_addr_gen.sv
// Circular head pointer for the data shift buffer and the (head - k) mod N read address.
module fir_addr_gen #(
    parameter int TAP_AW = 5
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [TAP_AW:0]   n_taps,
    input  logic              head_clr,
    input  logic              head_adv,
    input  logic [TAP_AW-1:0] k,
    output logic [TAP_AW-1:0] head,
    output logic [TAP_AW-1:0] rd_addr
);

    logic [TAP_AW-1:0] head_q, head_d;

    always_comb begin
        head_d = head_q;
        if (head_clr) begin
            head_d = '0;
        end else if (head_adv) begin
            head_d = ({1'b0, head_q} == n_taps - 1'b1) ? '0 : head_q + 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            head_q <= '0;
        end else begin
            head_q <= head_d;
        end
    end

    // Underflow adds N; taking only the low bits keeps N == 2**TAP_AW correct too.
    always_comb begin
        rd_addr = (head_q >= k) ? head_q - k : head_q + n_taps[TAP_AW-1:0] - k;
    end

    assign head = head_q;

endmodule

// File: rtl/fir_sched.sv
// FIR engine scheduler: ap_start/ap_done run control, input stream into a circular data
// BRAM, tap/data read and MAC sequencing, output stream handshake.
// Optional FIR_SCHED_CLR_EN: zero the data buffer at the start of every run.
//
// state | meaning
// IDLE  | waiting for ap_start, ap_idle high
// CLR   | writing zeros to data addresses 0..N-1
// LOAD  | waiting for one input sample
// CALC  | tap/data reads for k = 0..N-1
// DRAIN | last read in flight; head and count advance
// OUT   | result presented until sm_tready
// DONE  | one-cycle ap_done
module fir_sched
    import fir_pkg::*;
#(
    parameter int  DATA_WIDTH   = 32,
    parameter int  MAX_TAP_NUM  = 32,
    parameter int  MAX_DATA_NUM = 1024,
    localparam int TAP_AW       = tap_aw(MAX_TAP_NUM),
    localparam int DAT_CW       = dat_cw(MAX_DATA_NUM)
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    ap_start,
    output logic                    ap_done,
    output logic                    ap_idle,
    input  logic [TAP_AW:0]         tap_num,
    input  logic [DAT_CW-1:0]       data_num,
    input  logic                    ss_tvalid,
    output logic                    ss_tready,
    output logic                    dat_en,
    output logic [DATA_WIDTH/8-1:0] dat_we,
    output logic [TAP_AW-1:0]       dat_addr,
    output logic                    dat_wsel,
    output logic                    tap_en,
    output logic [TAP_AW-1:0]       tap_addr,
    output logic                    mac_clr,
    output logic                    mac_en,
    output logic                    sm_tvalid,
    output logic                    sm_tlast,
    input  logic                    sm_tready
);

    fir_sched_state_e       state_q, state_d;
    logic [TAP_AW:0]        n_q, n_d;
    logic [DAT_CW-1:0]      dnum_q, dnum_d;
    logic [DAT_CW-1:0]      cnt_q, cnt_d;
    logic [TAP_AW-1:0]      k_q, k_d;
    logic [BRAM_RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
    logic                   head_clr, head_adv, k_last;
    logic [TAP_AW-1:0]      head, rd_addr;

    assign k_last = ({1'b0, k_q} == n_q - 1'b1);
    assign mac_en = rd_pipe_q[BRAM_RD_LAT-1];

    fir_addr_gen #(
        .TAP_AW (TAP_AW)
    ) u_addr_gen (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .n_taps   (n_q),
        .head_clr (head_clr),
        .head_adv (head_adv),
        .k        (k_q),
        .head     (head),
        .rd_addr  (rd_addr)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= S_IDLE;
            n_q       <= '0;
            dnum_q    <= '0;
            cnt_q     <= '0;
            k_q       <= '0;
            rd_pipe_q <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            dnum_q    <= dnum_d;
            cnt_q     <= cnt_d;
            k_q       <= k_d;
            rd_pipe_q <= rd_pipe_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        dnum_d    = dnum_q;
        cnt_d     = cnt_q;
        k_d       = k_q;
        // Read data lands BRAM_RD_LAT cycles after each CALC address.
        rd_pipe_d = BRAM_RD_LAT'({rd_pipe_q, state_q == S_CALC});
        head_clr  = 1'b0;
        head_adv  = 1'b0;
        ap_idle   = 1'b0;
        ap_done   = 1'b0;
        ss_tready = 1'b0;
        dat_en    = 1'b0;
        dat_we    = '0;
        dat_addr  = '0;
        dat_wsel  = 1'b0;
        tap_en    = 1'b0;
        tap_addr  = '0;
        mac_clr   = 1'b0;
        sm_tvalid = 1'b0;
        sm_tlast  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) begin
                    n_d      = (tap_num == '0) ? {{TAP_AW{1'b0}}, 1'b1} : tap_num;
                    dnum_d   = data_num;
                    cnt_d    = '0;
                    k_d      = '0;
                    head_clr = 1'b1;
`ifdef FIR_SCHED_CLR_EN
                    state_d  = S_CLR;
`else
                    state_d  = (data_num == '0) ? S_DONE : S_LOAD;
`endif
                end
            end
`ifdef FIR_SCHED_CLR_EN
            S_CLR: begin
                dat_en   = 1'b1;
                dat_we   = '1;
                dat_addr = k_q;
                if (k_last) begin
                    k_d     = '0;
                    state_d = (dnum_q == '0) ? S_DONE : S_LOAD;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
`endif
            S_LOAD: begin
                ss_tready = 1'b1;
                dat_addr  = head;
                if (ss_tvalid) begin
                    dat_en   = 1'b1;
                    dat_we   = '1;
                    dat_wsel = 1'b1;
                    mac_clr  = 1'b1;
                    k_d      = '0;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                tap_en   = 1'b1;
                dat_en   = 1'b1;
                tap_addr = k_q;
                dat_addr = rd_addr;
                if (k_last) begin
                    k_d     = '0;
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_DRAIN: begin
                head_adv = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                state_d  = S_OUT;
            end
            S_OUT: begin
                sm_tvalid = 1'b1;
                sm_tlast  = (cnt_q == dnum_q);
                if (sm_tready) begin
                    state_d = (cnt_q == dnum_q) ? S_DONE : S_LOAD;
                end
            end
            S_DONE: begin
                ap_done = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

`ifndef FIR_SCHED_CLR_EN
        dat_wsel = 1'b1;
`endif
    end

endmodule

// File: tb/tb_fir_sched.sv
// Bench for fir_sched: external data/tap BRAMs and MAC live here; every run is compared
// with a sample-level convolution over a circular slot store.
module tb_fir_sched;

    localparam int TAP_AW = 5;
    localparam int DAT_CW = 11;
`ifdef FIR_SCHED_CLR_EN
    localparam logic WSEL_IDLE = 1'b0;
`else
    localparam logic WSEL_IDLE = 1'b1;
`endif

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic              ap_start, ap_done, ap_idle;
    logic [TAP_AW:0]   tap_num;
    logic [DAT_CW-1:0] data_num;
    logic              ss_tvalid, ss_tready;
    logic              dat_en, dat_wsel, tap_en, mac_clr, mac_en;
    logic [3:0]        dat_we;
    logic [TAP_AW-1:0] dat_addr, tap_addr;
    logic              sm_tvalid, sm_tlast, sm_tready;

    always #5 aclk = ~aclk;

    fir_sched dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .ap_start  (ap_start),
        .ap_done   (ap_done),
        .ap_idle   (ap_idle),
        .tap_num   (tap_num),
        .data_num  (data_num),
        .ss_tvalid (ss_tvalid),
        .ss_tready (ss_tready),
        .dat_en    (dat_en),
        .dat_we    (dat_we),
        .dat_addr  (dat_addr),
        .dat_wsel  (dat_wsel),
        .tap_en    (tap_en),
        .tap_addr  (tap_addr),
        .mac_clr   (mac_clr),
        .mac_en    (mac_en),
        .sm_tvalid (sm_tvalid),
        .sm_tlast  (sm_tlast),
        .sm_tready (sm_tready)
    );

    // External BRAMs (read latency 1) and accumulator.
    logic [31:0] dmem [0:31];
    logic [31:0] tmem [0:31];
    logic [31:0] ss_tdata, dat_rd, tap_rd, acc;
    logic        dmem_clear;

    always @(posedge aclk) begin
        if (dmem_clear) begin
            for (int i = 0; i < 32; i++) dmem[i] <= 32'd0;
        end else if (dat_en) begin
            if (dat_we != 4'h0) dmem[dat_addr] <= dat_wsel ? ss_tdata : 32'd0;
            dat_rd <= dmem[dat_addr];
        end
        if (tap_en) tap_rd <= tmem[tap_addr];
        if (mac_clr) acc <= 32'd0;
        else if (mac_en) acc <= acc + tap_rd * dat_rd;
    end

    // Event recorder, sampled mid-cycle.
    int                cyc = 0, mac_cnt = 0, done_cnt = 0, clr_wr_cnt = 0, wr_bad = 0;
    int                hs_q[$], vs_q[$];
    logic [TAP_AW-1:0] wr_q[$], rd_q[$], tp_q[$];
    logic [31:0]       y_q[$];
    logic              last_q[$];
    logic              vprev = 1'b0;

    always @(negedge aclk) begin
        cyc++;
        if (ss_tvalid && ss_tready) begin
            hs_q.push_back(cyc);
            wr_q.push_back(dat_addr);
            if (!(dat_en && dat_we == 4'hF && dat_wsel)) wr_bad++;
        end
        if (dat_en && dat_we != 4'h0 && !dat_wsel) clr_wr_cnt++;
        if (tap_en) begin
            rd_q.push_back(dat_addr);
            tp_q.push_back(tap_addr);
        end
        if (mac_en) mac_cnt++;
        if (sm_tvalid && !vprev) vs_q.push_back(cyc);
        vprev = sm_tvalid;
        if (sm_tvalid && sm_tready) begin
            y_q.push_back(acc);
            last_q.push_back(sm_tlast);
        end
        if (ap_done) done_cnt++;
    end

    int          checks = 0, errors = 0;
    logic [31:0] mslot [0:31];
    logic [31:0] xs[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check(tag, {ap_idle, ap_done, ss_tready, dat_en, dat_we, dat_addr, dat_wsel, tap_en,
                    tap_addr, mac_clr, mac_en, sm_tvalid, sm_tlast},
                   {1'b1, 3'b000, 4'h0, 5'd0, WSEL_IDLE, 1'b0, 5'd0, 4'h0});
    endtask

    task automatic send(input logic [31:0] v);
        bit ok;
        ok = 1'b0;
        ss_tdata  = v;
        ss_tvalid = 1'b1;
        for (int c = 0; c < 4000 && !ok; c++) begin
            @(negedge aclk);
            if (ss_tready) ok = 1'b1;
        end
        check("send_accepted", ok, 1'b1);
        @(posedge aclk);
        #1;
        ss_tvalid = 1'b0;
        ss_tdata  = 32'd0;
    endtask

    // mode 0: sm_tready high, back-to-back input; 1: random gaps and ready; 2: 5-cycle stall.
    task automatic run(input int ntap, input int dn, input int mode, input bit poke);
        int          n, budget, hb, vb, rb, yb, mb, db, cb, wbad;
        logic [31:0] exp_y[$];
        logic [31:0] s;
        bit          done_flag, seen;
        n = (ntap == 0) ? 1 : ntap;
`ifdef FIR_SCHED_CLR_EN
        for (int i = 0; i < n; i++) mslot[i] = 32'd0;
`endif
        for (int j = 0; j < dn; j++) begin
            mslot[j % n] = xs[j];
            s = 32'd0;
            for (int k = 0; k < n; k++) s += tmem[k] * mslot[((j - k) % n + n) % n];
            exp_y.push_back(s);
        end
        budget = 200 + dn * (n + 3) * 6;
        hb = hs_q.size(); vb = vs_q.size(); rb = rd_q.size(); yb = y_q.size();
        mb = mac_cnt; db = done_cnt; cb = clr_wr_cnt; wbad = wr_bad;
        done_flag = 1'b0;
        seen = 1'b0;
        sm_tready = (mode == 0);

        @(posedge aclk);
        #1;
        tap_num  = 6'(ntap);
        data_num = 11'(dn);
        ap_start = 1'b1;
        @(posedge aclk);
        #1;
        ap_start = 1'b0;
        tap_num  = 6'($urandom);
        data_num = 11'($urandom);

        fork
            begin : producer
                for (int j = 0; j < dn; j++) begin
                    if (mode == 1) begin
                        repeat ($urandom_range(0, 2)) @(posedge aclk);
                        #1;
                    end
                    send(xs[j]);
                end
            end
            begin : consumer
                if (mode == 1) begin
                    for (int c = 0; c < budget && !done_flag; c++) begin
                        @(posedge aclk);
                        #1;
                        sm_tready = 1'($urandom_range(0, 1));
                    end
                end else if (mode == 2) begin
                    for (int c = 0; c < budget && !seen; c++) begin
                        @(negedge aclk);
                        if (sm_tvalid) seen = 1'b1;
                    end
                    check("stall_reached_out", seen, 1'b1);
                    for (int i = 0; i < 5; i++) begin
                        check("stall_tvalid_held", sm_tvalid, 1'b1);
                        check("stall_ss_tready_low", ss_tready, 1'b0);
                        @(negedge aclk);
                    end
                    sm_tready = 1'b1;
                end
            end
            begin : waiter
                for (int c = 0; c < budget && !done_flag; c++) begin
                    @(negedge aclk);
                    if (ap_done) done_flag = 1'b1;
                end
                check("done_seen", done_flag, 1'b1);
            end
            begin : poker
                if (poke) begin
                    repeat (3) @(posedge aclk);
                    #1 ap_start = 1'b1;
                    @(posedge aclk);
                    #1 ap_start = 1'b0;
                end
            end
        join
        sm_tready = 1'b0;

        check("out_count", y_q.size() - yb, dn);
        for (int j = 0; j < dn && yb + j < y_q.size(); j++) begin
            check("y_value", y_q[yb + j], exp_y[j]);
            check("y_last", last_q[yb + j], (j == dn - 1));
        end
        for (int j = 0; j < dn && hb + j < hs_q.size(); j++) begin
            check("wr_addr", wr_q[hb + j], j % n);
            if (vb + j < vs_q.size()) check("latency_to_valid", vs_q[vb + j] - hs_q[hb + j], n + 2);
            if (mode == 0 && j > 0) check("throughput", hs_q[hb + j] - hs_q[hb + j - 1], n + 3);
            for (int k = 0; k < n && rb + j * n + k < rd_q.size(); k++) begin
                check("rd_addr", rd_q[rb + j * n + k], ((j - k) % n + n) % n);
                check("tap_addr", tp_q[rb + j * n + k], k);
            end
        end
        check("write_strobes", wr_bad - wbad, 0);
        check("mac_en_cycles", mac_cnt - mb, dn * n);
`ifdef FIR_SCHED_CLR_EN
        check("clr_writes", clr_wr_cnt - cb, n);
`else
        check("clr_writes", clr_wr_cnt - cb, 0);
`endif
        repeat (4) @(negedge aclk);
        check("done_once", done_cnt - db, 1);
        check("idle_after", ap_idle, 1'b1);
    endtask

    task automatic rand_run(input int ntap, input int dn, input int mode, input bit poke);
        xs.delete();
        for (int j = 0; j < dn; j++) xs.push_back(32'($urandom_range(0, 255)));
        for (int k = 0; k < 32; k++) tmem[k] = 32'($urandom_range(0, 255));
        run(ntap, dn, mode, poke);
    endtask

    initial begin
        int yb0, rb0, hb0, db0;
        bit in_calc;
        ap_start = 1'b0; ss_tvalid = 1'b0; ss_tdata = 32'd0; sm_tready = 1'b0;
        tap_num = '0; data_num = '0; dmem_clear = 1'b1;
        for (int i = 0; i < 32; i++) begin mslot[i] = 32'd0; tmem[i] = 32'd0; end

        repeat (3) @(posedge aclk);
        #1;
        check_idle("reset_outputs");
        @(negedge aclk);
        aresetn = 1'b1;
        dmem_clear = 1'b0;
        @(negedge aclk);
        check_idle("idle_after_reset");

        // N=4, samples 1,2,3, taps 1..4
        for (int k = 0; k < 4; k++) tmem[k] = 32'(k + 1);
        xs = {32'd1, 32'd2, 32'd3};
        yb0 = y_q.size();
        run(4, 3, 0, 1'b0);
        check("basic_y0", y_q[yb0], 32'd1);
        check("basic_y1", y_q[yb0 + 1], 32'd4);
        check("basic_y2", y_q[yb0 + 2], 32'd10);

        // N=3, 5 samples: write addresses and sample-4 read addresses
        hb0 = hs_q.size();
        rb0 = rd_q.size();
        rand_run(3, 5, 0, 1'b0);
        check("wr_seq_3", wr_q[hb0 + 3], 5'd0);
        check("wr_seq_4", wr_q[hb0 + 4], 5'd1);
        check("rd_s4_k0", rd_q[rb0 + 9], 5'd0);
        check("rd_s4_k1", rd_q[rb0 + 10], 5'd2);
        check("rd_s4_k2", rd_q[rb0 + 11], 5'd1);

        rand_run(2, 2, 2, 1'b0);
        for (int i = 0; i < 3; i++)
            rand_run($urandom_range(1, 8), $urandom_range(2, 10), 1, (i == 0));
        rand_run(0, 4, 0, 1'b0);
        rand_run(3, 0, 0, 1'b0);
        rand_run(32, 2, 0, 1'b0);

        // Reset while in CALC
        xs = {32'd3, 32'd4};
        db0 = done_cnt;
        sm_tready = 1'b1;
        @(posedge aclk);
        #1;
        tap_num = 6'd4; data_num = 11'd2; ap_start = 1'b1;
        @(posedge aclk);
        #1;
        ap_start = 1'b0;
        send(xs[0]);
        in_calc = 1'b0;
        for (int c = 0; c < 50 && !in_calc; c++) begin
            @(negedge aclk);
            if (tap_en) in_calc = 1'b1;
        end
        check("reached_calc", in_calc, 1'b1);
        aresetn = 1'b0;
        dmem_clear = 1'b1;
        #1;
        check_idle("reset_in_calc");
        @(posedge aclk);
        #1;
        check_idle("reset_in_calc_next");
        @(negedge aclk);
        aresetn = 1'b1;
        dmem_clear = 1'b0;
        sm_tready = 1'b0;
        for (int i = 0; i < 32; i++) mslot[i] = 32'd0;
        repeat (3) @(negedge aclk);
        check("no_done_on_reset", done_cnt - db0, 0);
        check_idle("idle_after_abort");
        rand_run(5, 4, 1, 1'b0);

        // Second run with N=3 sees the first run's samples unless the buffer is cleared
        for (int k = 0; k < 3; k++) tmem[k] = 32'(k + 1);
        xs = {32'd5, 32'd6, 32'd7};
        run(3, 3, 0, 1'b0);
        xs = {32'd2};
        run(3, 1, 0, 1'b0);
`ifdef FIR_SCHED_CLR_EN
        check("second_run_first_y", y_q[y_q.size() - 1], 32'd2);
`else
        check("second_run_first_y", y_q[y_q.size() - 1], 32'd34);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
